mio_responder: RTL and testbench

- Memory/IO responder for the multi-cycle CPU datapath's memory bus.
- Accepts one word read or write request at a time and inserts a configurable number of wait states.
- Serves an internal word RAM and a small IO page: LED register, switch input, free-running cycle counter.
- Returns read data and a one-cycle MIO_ready pulse that the datapath uses to gate its PC/state advance.

---
 rtl/mio_responder_if.sv | 14 +
 rtl/mio_responder.sv | 146 ++++++++++++++
 tb/tb_mio_responder.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/mio_responder_if.sv
// Memory bus between the multi-cycle CPU datapath (master) and mio_responder (slave).
// Handshake: master raises mem_req with mem_w/addr/wdata and holds them until
// MIO_ready; MIO_ready is a one-cycle pulse, rdata is valid in that cycle and held after.
interface mio_responder_if;
    logic        mem_req;
    logic        mem_w;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        MIO_ready;

    modport master (output mem_req, mem_w, addr, wdata, input rdata, MIO_ready);
    modport slave  (input mem_req, mem_w, addr, wdata, output rdata, MIO_ready);
endinterface

// File: rtl/mio_responder.sv
// Memory/IO responder: word RAM plus IO page (LED, cycle counter, switches) with
// configurable wait states. Define MIO_ERR_EN to add the bus_err output and misalignment checks.
module mio_responder #(
    parameter int         ADDR_WIDTH  = 10,
    parameter int         WAIT_CYCLES = 2,
    parameter logic [3:0] IO_PAGE     = 4'hE
) (
    input  logic                clk,
    input  logic                rst,
    mio_responder_if.slave      bus,
    input  logic [15:0]         sw,
    output logic [15:0]         led,
`ifdef MIO_ERR_EN
    output logic                bus_err,
`endif
    output logic [1:0]          state_dbg
);
    typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, RESP = 2'd2} state_t;

    localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t      state, state_nx;
    logic [3:0]  wait_cnt, wait_nx;
    logic        commit;
    logic [31:0] addr_q, wdata_q, rdata_q, cycle_cnt;
    logic        w_q;
    logic [31:0] ram [2**ADDR_WIDTH];

    // In IDLE the transaction is live on the bus (zero-wait commit); afterwards use the captured copy.
    logic [31:0] t_addr, t_wdata;
    logic        t_w;
    assign t_addr  = (state == IDLE) ? bus.addr  : addr_q;
    assign t_wdata = (state == IDLE) ? bus.wdata : wdata_q;
    assign t_w     = (state == IDLE) ? bus.mem_w : w_q;

    always_comb begin
        state_nx = state;
        wait_nx  = wait_cnt;
        commit   = 1'b0;
        case (state)
            IDLE: begin
                if (bus.mem_req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nx = RESP;
                        commit   = 1'b1;
                    end else begin
                        state_nx = BUSY;
                        wait_nx  = WAIT_LOAD;
                    end
                end
            end
            BUSY: begin
                if (wait_cnt == 4'd0) begin
                    state_nx = RESP;
                    commit   = 1'b1;
                end else begin
                    wait_nx = wait_cnt - 4'd1;
                end
            end
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    logic                  is_ram, is_io, mapped, acc_ok, err;
    logic [ADDR_WIDTH-1:0] ram_idx;
    logic [1:0]            io_sel;
    logic [31:0]           rd_val;
    assign is_ram  = (t_addr[31:ADDR_WIDTH+2] == '0);
    assign is_io   = (t_addr[31:28] == IO_PAGE);
    assign ram_idx = t_addr[ADDR_WIDTH+1:2];
    assign io_sel  = t_addr[3:2];

    always_comb begin
        rd_val = '0;
        mapped = 1'b0;
        if (is_ram) begin
            mapped = 1'b1;
            rd_val = ram[ram_idx];
        end else if (is_io) begin
            case (io_sel)
                2'd0: begin mapped = 1'b1; rd_val = {16'h0, led}; end
                2'd1: begin mapped = 1'b1; rd_val = cycle_cnt; end
                2'd2: begin mapped = 1'b1; rd_val = {16'h0, sw}; end
                default: begin mapped = 1'b0; rd_val = '0; end
            endcase
        end
    end

`ifdef MIO_ERR_EN
    assign acc_ok = (t_addr[1:0] == 2'b00);
    assign err    = !mapped || !acc_ok;
`else
    logic unused_bits;
    assign unused_bits = ^{t_addr[1:0], mapped};
    assign acc_ok      = 1'b1;
    assign err         = 1'b0;
`endif

    logic ram_we, led_we, err_q;
    // rst gates the write so a zero-wait commit cannot slip through while reset is held.
    assign ram_we = rst && commit && t_w && is_ram && acc_ok;
    assign led_we = commit && t_w && is_io && (io_sel == 2'd0) && acc_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            w_q       <= 1'b0;
            rdata_q   <= '0;
            led       <= '0;
            cycle_cnt <= '0;
            err_q     <= 1'b0;
        end else begin
            state     <= state_nx;
            wait_cnt  <= wait_nx;
            cycle_cnt <= cycle_cnt + 32'd1;
            if (state == IDLE && bus.mem_req) begin
                addr_q  <= bus.addr;
                wdata_q <= bus.wdata;
                w_q     <= bus.mem_w;
            end
            if (commit) begin
                err_q <= err;
                if (!t_w) rdata_q <= acc_ok ? rd_val : 32'h0;
            end
            if (led_we) led <= t_wdata[15:0];
        end
    end

    always_ff @(posedge clk) begin
        if (ram_we) ram[ram_idx] <= t_wdata;
    end

    assign bus.MIO_ready = (state == RESP);
    assign bus.rdata     = rdata_q;
    assign state_dbg     = state;
`ifdef MIO_ERR_EN
    assign bus_err = (state == RESP) && err_q;
`else
    logic unused_err;
    assign unused_err = err_q;
`endif
endmodule

// File: tb/tb_mio_responder.sv
// Bench for mio_responder: directed steps plus random traffic against an address-map model.
module tb_mio_responder;
    localparam int AW   = 10;
    localparam int WAIT = 2;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] sw;
    logic [15:0] led;
    logic [1:0]  state_dbg;
`ifdef MIO_ERR_EN
    logic        bus_err;
`endif

    mio_responder_if bus();

    mio_responder #(.ADDR_WIDTH(AW), .WAIT_CYCLES(WAIT), .IO_PAGE(4'hE)) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .sw        (sw),
        .led       (led),
`ifdef MIO_ERR_EN
        .bus_err   (bus_err),
`endif
        .state_dbg (state_dbg)
    );

    always #5 clk = ~clk;

    int edges = 0;
    always @(posedge clk) edges <= edges + 1;

    int checks = 0;
    int errors = 0;

    logic [31:0] ram_m [int];
    logic [15:0] led_m;
    logic [31:0] rd_m;
    logic [31:0] cnt_val;
    int          cnt_edge;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit in_ram(input logic [31:0] a);
        return (a >> (AW + 2)) == 0;
    endfunction
    function automatic bit in_io(input logic [31:0] a);
        return (a >> 28) == 32'hE;
    endfunction
    function automatic int io_reg(input logic [31:0] a);
        return int'((a % 16) / 4);
    endfunction
    function automatic int word_of(input logic [31:0] a);
        return int'((a / 4) % (1 << AW));
    endfunction
    function automatic bit misaligned(input logic [31:0] a);
        return (a % 4) != 0;
    endfunction

    function automatic bit ref_err(input logic [31:0] a);
`ifdef MIO_ERR_EN
        return misaligned(a) || !(in_ram(a) || (in_io(a) && io_reg(a) < 3));
`else
        return 1'b0;
`endif
    endfunction

    // Counter value just before edge number ce is cnt_val plus edges elapsed since cnt_edge.
    function automatic logic [31:0] ref_read(input logic [31:0] a, input int ce);
`ifdef MIO_ERR_EN
        if (misaligned(a)) return 32'h0;
`endif
        if (in_ram(a)) return ram_m.exists(word_of(a)) ? ram_m[word_of(a)] : 32'hx;
        if (in_io(a)) begin
            case (io_reg(a))
                0: return {16'h0, led_m};
                1: return cnt_val + 32'(ce - cnt_edge);
                2: return {16'h0, sw};
                default: return 32'h0;
            endcase
        end
        return 32'h0;
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] d);
`ifdef MIO_ERR_EN
        if (misaligned(a)) return;
`endif
        if (in_ram(a)) ram_m[word_of(a)] = d;
        else if (in_io(a) && io_reg(a) == 0) led_m = d[15:0];
    endtask

    task automatic model_reset();
        led_m    = 16'h0;
        rd_m     = 32'h0;
        cnt_val  = 32'h0;
        cnt_edge = edges;
    endtask

    // Called at a negedge; returns at the negedge after the idle cycle following MIO_ready.
    task automatic do_txn(input logic w, input logic [31:0] a, input logic [31:0] d, input bit keep);
        bit exp_err;
        int lat;
        bit seen;
        bus.mem_req = 1'b1;
        bus.mem_w   = w;
        bus.addr    = a;
        bus.wdata   = d;
        exp_err     = ref_err(a);
        if (w) ref_write(a, d);
        else   rd_m = ref_read(a, edges + WAIT);
        lat  = 0;
        seen = 1'b0;
        for (int i = 1; i <= 20 && !seen; i++) begin
            @(negedge clk);
            lat       = i;
            bus.addr  = $urandom;
            bus.wdata = $urandom;
            if (bus.MIO_ready) seen = 1'b1;
        end
        chk("latency", 32'(lat), 32'(WAIT + 1));
        chk("rdata", bus.rdata, rd_m);
        chk("led", {16'h0, led}, {16'h0, led_m});
`ifdef MIO_ERR_EN
        chk("bus_err", {31'h0, bus_err}, {31'h0, exp_err});
`endif
        if (keep) begin
            bus.addr  = a;
            bus.wdata = d;
        end else begin
            bus.mem_req = 1'b0;
        end
        @(negedge clk);
        chk("pulse_width", {31'h0, bus.MIO_ready}, 32'h0);
        chk("rdata_hold", bus.rdata, rd_m);
`ifdef MIO_ERR_EN
        chk("bus_err_clr", {31'h0, bus_err}, 32'h0);
`endif
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] c1, c2, old20, a;
        bit          pulse;
        int          r;
        bus.mem_req = 1'b0;
        bus.mem_w   = 1'b0;
        bus.addr    = '0;
        bus.wdata   = '0;
        sw          = 16'h1234;

        // Reset
        repeat (3) @(negedge clk);
        rst = 1'b1;
        model_reset();
        chk("rst_ready", {31'h0, bus.MIO_ready}, 32'h0);
        chk("rst_rdata", bus.rdata, 32'h0);
        chk("rst_led", {16'h0, led}, 32'h0);
        chk("rst_state", {30'h0, state_dbg}, 32'h0);
        do_txn(1'b0, 32'hE000_0004, 32'h0, 1'b0);
        chk("first_cnt_small", {31'h0, (bus.rdata < 32'd16)}, 32'h1);

        // RAM write/read
        do_txn(1'b1, 32'h0000_0010, 32'h1234_5678, 1'b0);
        do_txn(1'b0, 32'h0000_0010, 32'h0, 1'b0);

        // LED write and read back, switches
        do_txn(1'b1, 32'hE000_0000, 32'h0000_A5A5, 1'b0);
        do_txn(1'b0, 32'hE000_0000, 32'h0, 1'b0);
        sw = 16'($urandom);
        do_txn(1'b0, 32'hE000_0008, 32'h0, 1'b0);

        // Back-to-back counter reads
        do_txn(1'b0, 32'hE000_0004, 32'h0, 1'b1);
        c1 = bus.rdata;
        do_txn(1'b0, 32'hE000_0004, 32'h0, 1'b0);
        c2 = bus.rdata;
        chk("cnt_delta", c2 - c1, 32'(WAIT + 2));

        // Counter wrap
        force dut.cycle_cnt = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_cnt;
        cnt_val  = 32'hFFFF_FFFF;
        cnt_edge = edges;
        @(negedge clk);
        chk("cnt_wrap", dut.cycle_cnt, 32'h0);
        do_txn(1'b0, 32'hE000_0004, 32'h0, 1'b0);

        // Unmapped and misaligned
        do_txn(1'b0, 32'h8000_0000, 32'h0, 1'b0);
        do_txn(1'b0, 32'hE000_000C, 32'h0, 1'b0);
        do_txn(1'b1, 32'h0000_0012, 32'h0BAD_F00D, 1'b0);
        do_txn(1'b0, 32'h0000_0010, 32'h0, 1'b0);

        // Random traffic over a small pool of words plus IO registers
        for (int i = 0; i < 16; i++) do_txn(1'b1, 32'(i * 4), $urandom, 1'b0);
        for (int i = 0; i < 40; i++) begin
            r  = $urandom_range(0, 9);
            sw = 16'($urandom);
            a  = 32'($urandom_range(0, 15) * 4);
            if (r <= 3)      do_txn(1'b1, a, $urandom, 1'b0);
            else if (r <= 6) do_txn(1'b0, a, 32'h0, 1'b0);
            else if (r == 7) do_txn(1'b1, 32'hE000_0000, $urandom, 1'b0);
            else if (r == 8) do_txn(1'b0, 32'hE000_0008, 32'h0, $urandom_range(0, 1) == 1);
            else             do_txn(1'b0, 32'hE000_0004, 32'h0, 1'b0);
        end

        // Reset during BUSY of a write
        do_txn(1'b1, 32'h0000_0020, 32'hCAFE_0020, 1'b0);
        old20       = ram_m[8];
        bus.mem_req = 1'b1;
        bus.mem_w   = 1'b1;
        bus.addr    = 32'h0000_0020;
        bus.wdata   = 32'hDEAD_BEEF;
        @(negedge clk);
        rst         = 1'b0;
        bus.mem_req = 1'b0;
        pulse       = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (bus.MIO_ready) pulse = 1'b1;
        end
        rst = 1'b1;
        model_reset();
        chk("midrst_no_pulse", {31'h0, pulse}, 32'h0);
        chk("midrst_state", {30'h0, state_dbg}, 32'h0);
        chk("midrst_led", {16'h0, led}, 32'h0);
        chk("midrst_rdata", bus.rdata, 32'h0);
        do_txn(1'b0, 32'h0000_0020, 32'h0, 1'b0);
        chk("midrst_word", bus.rdata, old20);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
